arm_imm_encoder: RTL and testbench



---
 rtl/arm_imm_encoder_if.sv | 25 ++
 rtl/arm_imm_encoder.sv | 127 ++++++++++++
 tb/tb_arm_imm_encoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/arm_imm_encoder_if.sv
// arm_imm_encoder_if
//   Request/response bundle for the ARM immediate encoder.
//   Request channel : in_valid, in_ready, in_value[31:0]
//   Result channel  : out_valid, out_ready, out_found, out_shift_operand[11:0]
//   slave  - the encoder side
//   master - the requester / result consumer side
interface arm_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_found;
  logic [11:0] out_shift_operand;

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_found, out_shift_operand
  );

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_found, out_shift_operand
  );
endinterface

// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder
//   Searches for the ARM data-processing immediate {rotate_imm, imm8} whose
//   value ROR(imm8, 2*rotate_imm) equals a 32-bit constant. The search walks
//   rotations 0..15, CHECKS_PER_CYCLE of them per cycle, lowest rotation wins.
// Ports
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - arm_imm_encoder_if.slave (request and result valid/ready channels)
//   busy - high while searching or holding a result
module arm_imm_encoder #(
  parameter int CHECKS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  arm_imm_encoder_if.slave      bus,
  output logic                  busy
);

  localparam int CPC = CHECKS_PER_CYCLE;

  generate
    if (CPC != 1 && CPC != 2 && CPC != 4 && CPC != 8 && CPC != 16) begin : g_bad_cpc
      $error("arm_imm_encoder: CHECKS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Counter value of the final group; reaching it without a hit means a miss.
  localparam logic [3:0] LAST_GRP = 4'(16 - CPC);
  localparam logic [3:0] CNT_STEP = 4'(CPC);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] value, value_nxt;
  logic        found, found_nxt;
  logic [11:0] shop, shop_nxt;

  // Rotate left by twice the rotation index; the doubled word keeps r=0 well
  // defined (no shift by 32) and wraps all bits, no sign extension.
  function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
    logic [63:0] t;
    t = {v, v} << {r, 1'b0};
    return t[63:32];
  endfunction

  logic [31:0] rot [CPC];

  for (genvar k = 0; k < CPC; k++) begin : g_cand
    assign rot[k] = rol2(value, cnt + 4'(k));
  end

  logic       hit;
  logic [3:0] hit_r;
  logic [7:0] hit_imm;

  // Pick the lowest hitting candidate of this group.
  always_comb begin
    hit     = 1'b0;
    hit_r   = '0;
    hit_imm = '0;
    for (int k = 0; k < CPC; k++) begin
      if (!hit && rot[k][31:8] == 24'h0) begin
        hit     = 1'b1;
        hit_r   = cnt + 4'(k);
        hit_imm = rot[k][7:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    value_nxt = value;
    found_nxt = found;
    shop_nxt  = shop;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          value_nxt = bus.in_value;
          cnt_nxt   = '0;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          found_nxt = 1'b1;
          shop_nxt  = {hit_r, hit_imm};
          state_nxt = DONE;
        end else if (cnt == LAST_GRP) begin
          found_nxt = 1'b0;
          shop_nxt  = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_STEP;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      value <= '0;
      found <= 1'b0;
      shop  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      value <= value_nxt;
      found <= found_nxt;
      shop  <= shop_nxt;
    end
  end

  assign bus.in_ready          = (state == IDLE);
  assign bus.out_valid         = (state == DONE);
  assign bus.out_found         = found;
  assign bus.out_shift_operand = shop;
  assign busy                  = (state != IDLE);

endmodule

// File: tb/tb_arm_imm_encoder.sv
module tb_arm_imm_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic busy1, busy4;

  arm_imm_encoder_if b1();
  arm_imm_encoder_if b4();

  arm_imm_encoder #(.CHECKS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .busy(busy1)
  );
  arm_imm_encoder #(.CHECKS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave), .busy(busy4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          which;
    logic [31:0] value;
    logic        found;
    logic [11:0] so;
    int          lat;
  } vec_t;

  typedef struct {
    logic        found;
    logic [11:0] so;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [31:0] val);
    if (which == 4) begin
      b4.in_valid = v; b4.in_value = val;
    end else begin
      b1.in_valid = v; b1.in_value = val;
    end
  endtask

  task automatic set_ready(input int which, input logic r);
    if (which == 4) b4.out_ready = r;
    else b1.out_ready = r;
  endtask

  // {busy, in_ready, out_valid, out_found, out_shift_operand}
  function automatic logic [15:0] snap(input int which);
    if (which == 4)
      return {busy4, b4.in_ready, b4.out_valid, b4.out_found, b4.out_shift_operand};
    else
      return {busy1, b1.in_ready, b1.out_valid, b1.out_found, b1.out_shift_operand};
  endfunction

  // Accept a request, then wait (bounded) for the result; returns cycles
  // counted from the acceptance edge.
  task automatic start_and_wait(input int which, input logic [31:0] val,
                                input logic found, input logic [11:0] so,
                                input int lat, output logic [15:0] s);
    int   edges;
    exp_t e;
    @(negedge clk);
    drive(which, 1'b1, val);
    chk("in_ready_before_accept", 32'(snap(which)[14]), 32'd1);
    @(posedge clk); #1;
    drive(which, 1'b0, 32'hDEAD_BEEF);
    sb.push_back('{found: found, so: so, lat: lat});
    edges = 0;
    s = snap(which);
    while (!s[13] && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      s = snap(which);
    end
    e = sb.pop_front();
    if (!s[13]) begin
      chk("out_valid_timeout", 32'd0, 32'd1);
    end else begin
      chk($sformatf("latency_%h", val), 32'(edges), 32'(e.lat));
      chk($sformatf("found_%h", val), 32'(s[12]), 32'(e.found));
      chk($sformatf("shift_operand_%h", val), 32'(s[11:0]), 32'(e.so));
      chk("busy_in_done", 32'(s[15]), 32'd1);
      chk("in_ready_in_done", 32'(s[14]), 32'd0);
    end
  endtask

  task automatic release_result(input int which);
    logic [15:0] s;
    set_ready(which, 1'b1);
    @(posedge clk); #1;
    set_ready(which, 1'b0);
    s = snap(which);
    chk("in_ready_after_consume", 32'(s[14]), 32'd1);
    chk("out_valid_after_consume", 32'(s[13]), 32'd0);
    chk("busy_after_consume", 32'(s[15]), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] s;
    start_and_wait(v.which, v.value, v.found, v.so, v.lat, s);
    release_result(v.which);
  endtask

  initial begin
    logic [15:0] s;

    tbl[0]  = '{which: 1, value: 32'h0000_00FF, found: 1'b1, so: 12'h0FF, lat: 1};
    tbl[1]  = '{which: 1, value: 32'hFF00_0000, found: 1'b1, so: 12'h4FF, lat: 5};
    tbl[2]  = '{which: 1, value: 32'h0000_03FC, found: 1'b1, so: 12'hFFF, lat: 16};
    tbl[3]  = '{which: 1, value: 32'hC000_003F, found: 1'b1, so: 12'h1FF, lat: 2};
    tbl[4]  = '{which: 1, value: 32'hF000_000F, found: 1'b1, so: 12'h2FF, lat: 3};
    tbl[5]  = '{which: 1, value: 32'h0000_0101, found: 1'b0, so: 12'h000, lat: 16};
    tbl[6]  = '{which: 1, value: 32'h8000_0000, found: 1'b1, so: 12'h102, lat: 2};
    tbl[7]  = '{which: 1, value: 32'h0000_0000, found: 1'b1, so: 12'h000, lat: 1};
    tbl[8]  = '{which: 4, value: 32'h0000_0101, found: 1'b0, so: 12'h000, lat: 4};
    tbl[9]  = '{which: 4, value: 32'hFF00_0000, found: 1'b1, so: 12'h4FF, lat: 2};
    tbl[10] = '{which: 4, value: 32'h0000_03FC, found: 1'b1, so: 12'hFFF, lat: 4};
    tbl[11] = '{which: 4, value: 32'h0000_00FF, found: 1'b1, so: 12'h0FF, lat: 1};

    rst = 1'b0;
    drive(1, 1'b0, 32'h0);
    drive(4, 1'b0, 32'h0);
    set_ready(1, 1'b0);
    set_ready(4, 1'b0);
    #12;
    chk("reset_state_cpc1", 32'(snap(1)), 32'h4000);
    chk("reset_state_cpc4", 32'(snap(4)), 32'h4000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Backpressure: result held, new requests ignored while DONE.
    start_and_wait(1, 32'h0000_00FF, 1'b1, 12'h0FF, 1, s);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1'b1, 32'h0000_0101 + 32'(i));
      @(posedge clk); #1;
      chk($sformatf("backpressure_hold_%0d", i), 32'(snap(1)), 32'hB0FF);
    end
    drive(1, 1'b0, 32'h0);
    release_result(1);
    run_vec('{which: 1, value: 32'h0000_0000, found: 1'b1, so: 12'h000, lat: 1});

    // out_ready while nothing pending must not disturb the next request.
    set_ready(1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_out_ready_no_effect", 32'(snap(1)[14:13]), 32'h2);
    set_ready(1, 1'b0);

    // Asynchronous reset in the middle of a search.
    @(negedge clk);
    drive(1, 1'b1, 32'hFF00_0000);
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_mid_search", 32'(snap(1)[15:13]), 32'h4);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_values", 32'(snap(1)), 32'h4000);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("no_stale_result_%0d", i), 32'(snap(1)[15:13]), 32'h2);
    end
    run_vec('{which: 1, value: 32'hC000_003F, found: 1'b1, so: 12'h1FF, lat: 2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
